decode_rename_stage: RTL
========================

Name: decode_rename_stage

Overview:
- Parametrised N-wide decode/rename stage between the Fetch/Decode and Decode/Dispatch registers.
- Decodes ISSUE_W instructions per cycle and reads sources from an internal architectural register file (ARF) plus a rename register file (RRF) built as a circular buffer.
- Allocates RRF tags to destinations, with intra-group dependency forwarding, writeback bypass and in-order retire.
- Output is a registered valid/ready packet stream. Unlike a fixed two-way decoder, it stalls the whole group atomically when rename registers are insufficient.

Parameters:
- ISSUE_W, 2, instructions per group (1..4).
- XLEN, 32, data width.
- RRF_DEPTH, 16, rename entries (power of 2, ≥ ISSUE_W).
- TAG_W, $clog2(RRF_DEPTH), RRF tag width.
- PKT_W, 2*XLEN+TAG_W+40, output packet width per slot.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all speculative state.
- in_valid  in  1  fetch group valid.
- in_mask  in  ISSUE_W  per-slot valid; slot 0 is oldest.
- in_inst  in  32*ISSUE_W  instructions; slot i is in bits [32i+31:32i].
- in_ready  out  1  group accepted when in_valid && in_ready.
- stall_rrf  out  1  in_valid && RRF free entries < allocations needed.
- out_valid  out  1  registered group valid.
- out_mask  out  ISSUE_W  registered slot mask.
- out_pkt  out  PKT_W*ISSUE_W  per slot, MSB→LSB: rs2 value/tag (XLEN), rs2_valid, rs1 value/tag (XLEN), rs1_valid, dest tag (TAG_W), rd (5), map_en, inst (32).
- out_ready  in  1  dispatch accepts.
- wb_en  in  ISSUE_W  writeback strobes.
- wb_tag  in  TAG_W*ISSUE_W  writeback tags.
- wb_data  in  XLEN*ISSUE_W  writeback data.
- ret_cnt  in  $clog2(ISSUE_W+1)  oldest RRF entries retiring this cycle.
- free_cnt  out  TAG_W+1  free RRF entries.

Behaviour:
- Reset (rst=1 at a clock edge): ARF values 0, busy 0, map tags 0, RRF ready 0, head=tail=0, free_cnt=RRF_DEPTH, out_valid=0, out_mask=0, out_pkt=0.
- Decode, per slot:
  - map_en=1 for opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111 when rd≠0.
  - rs1 is used by all opcodes except LUI/AUIPC/JAL. rs2 is used by 0110011, 0100011, 1100011.
  - An unused source yields value 0, valid 1.
- Allocation:
  - need = popcount(in_mask & map_en).
  - in_ready = !flush && (!out_valid || out_ready) && free_cnt ≥ need.
  - Groups are all-or-nothing; there is no partial acceptance.
  - Slot i's tag = tail + (number of older allocating slots), mod RRF_DEPTH.
  - Accepted slots set map busy=1 and map tag=that tag, and record rd in the RRF entry with ready=0. tail advances by need.
- Source lookup priority:
  1. x0 → 0, valid 1.
  2. Youngest older slot in the same group with map_en and matching rd → that slot's tag zero-extended, valid 0.
  3. ARF not busy → ARF value, valid 1.
  4. Busy and the RRF entry is ready → RRF data, valid 1.
  5. Busy and a same-cycle wb_en carries a matching tag → wb_data, valid 1.
  6. Otherwise → tag zero-extended, valid 0.
- Output register:
  - Latency 1.
  - out_valid, out_mask and out_pkt are held stable while out_valid && !out_ready.
  - out_valid clears after a handshake when no new group is accepted.
- Writeback: writes RRF data and sets ready for that tag.
  - Already-issued packets are not patched; tag matching is dispatch's job.
- Retire:
  - ret_cnt entries from head, oldest first. Each writes its RRF data to ARF[rd] and clears its RRF ready.
  - Busy is cleared only if the map tag still equals the retiring tag and no same-cycle allocation renames that rd. Same-cycle rename wins.
  - head advances by ret_cnt.
  - Retiring a not-ready entry, or ret_cnt > occupancy, is illegal (assertion only).
- free_cnt:
  - Next value = free_cnt − need(accepted) + ret_cnt.
  - Entries freed this cycle are not allocatable until the next cycle: the stall check uses the current value.
- Flush (priority below rst, above everything else):
  - Clears all busy bits and RRF ready.
  - head=tail=0, free_cnt=RRF_DEPTH, out_valid=0.
  - ARF values are kept; same-cycle accept, writeback and retire are ignored.
- Wrap-around: head and tail are TAG_W bits and wrap modulo RRF_DEPTH; full and empty are distinguished by free_cnt.

Test Plan:
- Reset, then group {addi x1,x0,5 ; add x2,x1,x1}, mask=11 → next cycle: slot0 tag 0, rs1 value 0/valid 1; slot1 tag 1, rs1=rs2=tag 0/valid 0; free_cnt=14.
- wb_en tag0 data 5, ret_cnt=1, then group {add x3,x1,x0} → ARF x1=5, busy cleared; slot0 rs1=5/valid 1, rs2=0/valid 1.
- Fill to free_cnt=1, then offer a 2-allocation group → in_ready=0, stall_rrf=1. Retire 1 → accepted the following cycle with tags wrapping 15→0.
- out_ready=0 for 3 cycles with a group pending → out_pkt stable and in_ready=0. out_ready=1 → handshake, the next group appears one cycle later.
- Source tag being written back in the same cycle as decode (wb tag 2, data 0xDEAD) → rs valid 1, value 0xDEAD.
- flush while out_valid=1 and 6 entries allocated → next cycle out_valid=0, free_cnt=16, a read of a previously busy register returns its ARF value, valid 1.

Source files
------------

// File: rtl/decode_rename_stage.sv
// N-wide decode/rename stage: decodes a fetch group, renames destinations onto a
// circular rename register file (RRF) and emits one registered valid/ready packet per group.
module decode_rename_stage #(
    parameter int ISSUE_W   = 2,
    parameter int XLEN      = 32,
    parameter int RRF_DEPTH = 16,
    parameter int TAG_W     = $clog2(RRF_DEPTH),
    parameter int PKT_W     = 2*XLEN + TAG_W + 40
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    input  logic [ISSUE_W-1:0]             in_mask,
    input  logic [32*ISSUE_W-1:0]          in_inst,
    output logic                           in_ready,
    output logic                           stall_rrf,
    output logic                           out_valid,
    output logic [ISSUE_W-1:0]             out_mask,
    output logic [PKT_W*ISSUE_W-1:0]       out_pkt,
    input  logic                           out_ready,
    input  logic [ISSUE_W-1:0]             wb_en,
    input  logic [TAG_W*ISSUE_W-1:0]       wb_tag,
    input  logic [XLEN*ISSUE_W-1:0]        wb_data,
    input  logic [$clog2(ISSUE_W+1)-1:0]   ret_cnt,
    output logic [TAG_W:0]                 free_cnt
);

    localparam int RET_W = $clog2(ISSUE_W+1);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Architectural state, rename map and RRF
    logic [XLEN-1:0]      arf_q      [32];
    logic [31:0]          busy_q;
    logic [TAG_W-1:0]     map_tag_q  [32];
    logic [XLEN-1:0]      rrf_data_q [RRF_DEPTH];
    logic [4:0]           rrf_rd_q   [RRF_DEPTH];
    logic [RRF_DEPTH-1:0] rrf_ready_q;
    logic [TAG_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]       free_q, free_d;

    logic                     out_valid_q;
    logic [ISSUE_W-1:0]       out_mask_q;
    logic [PKT_W*ISSUE_W-1:0] out_pkt_q, pkt_d;

    logic [6:0]         opc      [ISSUE_W];
    logic [4:0]         rd       [ISSUE_W];
    logic [4:0]         rs1      [ISSUE_W];
    logic [4:0]         rs2      [ISSUE_W];
    logic [ISSUE_W-1:0] rs1_used, rs2_used, map_en, alloc;
    logic [TAG_W-1:0]   slot_tag [ISSUE_W];
    logic [TAG_W:0]     need;
    logic               accept;

    logic [1:0][XLEN-1:0] src_val [ISSUE_W];
    logic [1:0]           src_vld [ISSUE_W];

    logic [ISSUE_W-1:0] ret_en;
    logic [TAG_W-1:0]   ret_idx [ISSUE_W];
    logic [4:0]         ret_rd  [ISSUE_W];
    logic [TAG_W:0]     occupancy;
    logic               ret_illegal;

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so no path can leave a variable unassigned and infer a latch.
    always_comb begin
        need = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            opc[i]      = in_inst[32*i +: 7];
            rd[i]       = in_inst[32*i+7 +: 5];
            rs1[i]      = in_inst[32*i+15 +: 5];
            rs2[i]      = in_inst[32*i+20 +: 5];
            rs1_used[i] = !(opc[i] inside {OP_LUI, OP_AUIPC, OP_JAL});
            rs2_used[i] = opc[i] inside {OP_REG, OP_STORE, OP_BRANCH};
            map_en[i]   = (opc[i] inside {OP_REG, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR})
                          && (rd[i] != 5'd0);
            alloc[i]    = in_mask[i] && map_en[i];
            slot_tag[i] = tail_q + need[TAG_W-1:0];
            need        = need + {{TAG_W{1'b0}}, alloc[i]};
        end
    end

    assign in_ready  = !flush && (!out_valid_q || out_ready) && (free_q >= need);
    assign stall_rrf = in_valid && (free_q < need);
    assign accept    = in_valid && in_ready;

    always_comb begin : src_lookup
        logic [4:0]       r;
        logic             used, fwd_hit, wb_hit;
        logic [TAG_W-1:0] fwd_tag, mtag;
        logic [XLEN-1:0]  wb_val;
        r = '0; used = 1'b0; fwd_hit = 1'b0; wb_hit = 1'b0;
        fwd_tag = '0; mtag = '0; wb_val = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            src_val[i] = '0;
            src_vld[i] = '0;
            for (int s = 0; s < 2; s++) begin
                r    = (s == 0) ? rs1[i] : rs2[i];
                used = (s == 0) ? rs1_used[i] : rs2_used[i];
                // Later (younger) older slots overwrite, so the youngest producer wins
                fwd_hit = 1'b0;
                fwd_tag = '0;
                for (int j = 0; j < i; j++) begin
                    if (alloc[j] && rd[j] == r) begin
                        fwd_hit = 1'b1;
                        fwd_tag = slot_tag[j];
                    end
                end
                mtag   = map_tag_q[r];
                wb_hit = 1'b0;
                wb_val = '0;
                for (int k = 0; k < ISSUE_W; k++) begin
                    if (wb_en[k] && wb_tag[k*TAG_W +: TAG_W] == mtag) begin
                        wb_hit = 1'b1;
                        wb_val = wb_data[k*XLEN +: XLEN];
                    end
                end
                if (!used || r == 5'd0) begin
                    src_val[i][s] = '0;
                    src_vld[i][s] = 1'b1;
                end else if (fwd_hit) begin
                    src_val[i][s] = XLEN'(fwd_tag);
                    src_vld[i][s] = 1'b0;
                end else if (!busy_q[r]) begin
                    src_val[i][s] = arf_q[r];
                    src_vld[i][s] = 1'b1;
                end else if (rrf_ready_q[mtag]) begin
                    src_val[i][s] = rrf_data_q[mtag];
                    src_vld[i][s] = 1'b1;
                end else if (wb_hit) begin
                    src_val[i][s] = wb_val;
                    src_vld[i][s] = 1'b1;
                end else begin
                    src_val[i][s] = XLEN'(mtag);
                    src_vld[i][s] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        pkt_d = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            pkt_d[i*PKT_W +: PKT_W] = {src_val[i][1], src_vld[i][1], src_val[i][0], src_vld[i][0],
                                       alloc[i] ? slot_tag[i] : {TAG_W{1'b0}},
                                       rd[i], map_en[i], in_inst[32*i +: 32]};
        end
    end

    always_comb begin
        for (int r = 0; r < ISSUE_W; r++) begin
            ret_en[r]  = RET_W'(r) < ret_cnt;
            ret_idx[r] = head_q + TAG_W'(r);
            ret_rd[r]  = rrf_rd_q[ret_idx[r]];
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        free_d = free_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            free_d = (TAG_W+1)'(RRF_DEPTH);
        end else begin
            head_d = head_q + TAG_W'(ret_cnt);
            free_d = free_q + (TAG_W+1)'(ret_cnt);
            if (accept) begin
                tail_d = tail_q + need[TAG_W-1:0];
                free_d = free_d - need;
            end
        end
    end

    // NOTE: sequential state is written with non-blocking '<=' only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            free_q      <= (TAG_W+1)'(RRF_DEPTH);
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_pkt_q   <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            free_q <= free_d;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_mask_q  <= in_mask;
                out_pkt_q   <= pkt_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // NOTE: rrf_data_q/rrf_rd_q are intentionally not reset; a ready or busy bit
    // gates every read of them, so only those control bits need a reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                arf_q[r]     <= '0;
                map_tag_q[r] <= '0;
            end
            busy_q      <= '0;
            rrf_ready_q <= '0;
        end else if (flush) begin
            busy_q      <= '0;
            rrf_ready_q <= '0;
        end else begin
            for (int k = 0; k < ISSUE_W; k++) begin
                if (wb_en[k]) begin
                    rrf_data_q[wb_tag[k*TAG_W +: TAG_W]]  <= wb_data[k*XLEN +: XLEN];
                    rrf_ready_q[wb_tag[k*TAG_W +: TAG_W]] <= 1'b1;
                end
            end
            for (int r = 0; r < ISSUE_W; r++) begin
                if (ret_en[r]) begin
                    if (ret_rd[r] != 5'd0) arf_q[ret_rd[r]] <= rrf_data_q[ret_idx[r]];
                    rrf_ready_q[ret_idx[r]] <= 1'b0;
                    if (map_tag_q[ret_rd[r]] == ret_idx[r]) busy_q[ret_rd[r]] <= 1'b0;
                end
            end
            // Allocation is written last so a same-cycle rename overrides a retire's busy clear
            if (accept) begin
                for (int i = 0; i < ISSUE_W; i++) begin
                    if (alloc[i]) begin
                        busy_q[rd[i]]            <= 1'b1;
                        map_tag_q[rd[i]]         <= slot_tag[i];
                        rrf_rd_q[slot_tag[i]]    <= rd[i];
                        rrf_ready_q[slot_tag[i]] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        occupancy   = (TAG_W+1)'(RRF_DEPTH) - free_q;
        ret_illegal = (TAG_W+1)'(ret_cnt) > occupancy;
        for (int r = 0; r < ISSUE_W; r++) begin
            if (ret_en[r] && !rrf_ready_q[ret_idx[r]]) ret_illegal = 1'b1;
        end
    end

    a_retire_legal: assert property (@(posedge clk) disable iff (rst || flush) !ret_illegal);

    assign out_valid = out_valid_q;
    assign out_mask  = out_mask_q;
    assign out_pkt   = out_pkt_q;
    assign free_cnt  = free_q;

endmodule
